// File: rtl/modsqr_iter_sequencer_pkg.sv
// Shared types for the VDF squaring sequencer: coefficient type, FSM state encoding
// and default vector geometry.
package modsqr_iter_sequencer_pkg;

    localparam int NUM_ELEMENTS_DEF = 10;
    localparam int BIT_LEN_DEF      = 17;

    typedef logic [BIT_LEN_DEF-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/modsqr_iter_sequencer_sat_counter.sv
// Saturating up-counter used as the no-progress watchdog; sat flags the all-ones value.
module modsqr_iter_sequencer_sat_counter #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic sat
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && !sat)
            count <= count + W'(1);
    end

    assign sat = &count;

endmodule

// File: rtl/modsqr_iter_sequencer.sv
// Drives one VDF evaluation: seeds the modular squarer, counts T squarings and returns
// y = x^(2^T) over a valid/ready port, with abort and a no-progress watchdog.
module modsqr_iter_sequencer
    import modsqr_iter_sequencer_pkg::*;
#(
    parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
    parameter int BIT_LEN      = BIT_LEN_DEF,
    parameter int ITER_W       = 64,
    parameter int WDOG_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tbl_ready,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [ITER_W-1:0]                     cmd_iters,
    input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  cmd_x,
    input  logic                                  abort,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  res_y,
    output logic [ITER_W-1:0]                     res_done_cnt,
    output logic                                  res_err,
    output logic                                  busy,
    output logic                                  sq_start,
    output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  sq_in,
    input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  sq_out,
    input  logic                                  sq_valid
);

    seq_state_e        state;
    logic [ITER_W-1:0] iter_tgt;
    logic [ITER_W-1:0] cnt;
    logic [ITER_W-1:0] cnt_inc;
    logic              accept;
    logic              wdog_clr;
    logic              wdog_inc;
    logic              wdog_sat;

    assign accept   = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign cnt_inc  = cnt + ITER_W'(1);
    assign wdog_clr = accept || ((state == ST_RUN) && sq_valid);
    assign wdog_inc = (state == ST_RUN) && !sq_valid;

    modsqr_iter_sequencer_sat_counter #(.W(WDOG_W)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wdog_clr),
        .inc   (wdog_inc),
        .sat   (wdog_sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cmd_ready    <= 1'b0;
            res_valid    <= 1'b0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
            sq_start     <= 1'b0;
            sq_in        <= '0;
            res_y        <= '0;
            res_done_cnt <= '0;
            iter_tgt     <= '0;
            cnt          <= '0;
        end else begin
            sq_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= tbl_ready;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        sq_in     <= cmd_x;
                        iter_tgt  <= cmd_iters;
                        cnt       <= '0;
                        res_err   <= 1'b0;
                        if (cmd_iters == '0) begin
                            // Zero iterations: the seed is the answer, squarer untouched.
                            state        <= ST_DONE;
                            res_valid    <= 1'b1;
                            res_y        <= cmd_x;
                            res_done_cnt <= '0;
                        end else begin
                            state    <= ST_LAUNCH;
                            sq_start <= 1'b1;
                            res_y    <= '0;
                        end
                    end
                end
                ST_LAUNCH: begin
                    // Any sq_valid here is stale output from the previous job.
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= tbl_ready;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= tbl_ready;
                    end else if (sq_valid) begin
                        cnt   <= cnt_inc;
                        res_y <= sq_out;
                        if (cnt_inc == iter_tgt) begin
                            state        <= ST_DONE;
                            res_valid    <= 1'b1;
                            res_done_cnt <= iter_tgt;
                            res_err      <= 1'b0;
                        end
                    end else if (wdog_sat) begin
                        state        <= ST_DONE;
                        res_valid    <= 1'b1;
                        res_done_cnt <= cnt;
                        res_err      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (abort || res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= tbl_ready;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modsqr_iter_sequencer.sv
// Directed bench for modsqr_iter_sequencer with a behavioural squarer that squares
// coefficient 0 mod N every 8 cycles after each sq_start.
module tb_modsqr_iter_sequencer;

    localparam int NE = 10;
    localparam int BL = 17;
    localparam int IW = 64;

    typedef logic [NE-1:0][BL-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tbl_ready;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_iters;
    vec_t          cmd_x;
    logic          abort;
    logic          res_valid;
    logic          res_ready;
    vec_t          res_y;
    logic [IW-1:0] res_done_cnt;
    logic          res_err;
    logic          busy;
    logic          sq_start;
    vec_t          sq_in;
    vec_t          sq_out;
    logic          sq_valid;

    int     vectors = 0;
    int     miscompares = 0;
    int     starts = 0;
    int     valids = 0;
    longint mod_n = 1000003;
    int     pulse_limit = -1;
    longint m_val;
    int     m_phase;
    int     m_pulses;
    logic   m_run;

    always #5 clk = ~clk;

    modsqr_iter_sequencer #(
        .NUM_ELEMENTS(NE), .BIT_LEN(BL), .ITER_W(IW), .WDOG_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tbl_ready(tbl_ready), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_iters(cmd_iters), .cmd_x(cmd_x), .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_done_cnt(res_done_cnt), .res_err(res_err), .busy(busy),
        .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid)
    );

    function automatic vec_t mkvec(input longint v);
        vec_t r;
        r = '0;
        r[0] = v[BL-1:0];
        return r;
    endfunction

    function automatic longint ref_pow(input longint x, input int t, input longint n);
        longint y;
        y = x;
        for (int i = 0; i < t; i++) y = (y * y) % n;
        return y;
    endfunction

    // Behavioural squarer: free-running once seeded, optionally stops after pulse_limit.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_val    <= 0;
            m_phase  <= 0;
            m_pulses <= 0;
            sq_valid <= 1'b0;
            sq_out   <= '0;
        end else begin
            sq_valid <= 1'b0;
            if (sq_start) begin
                m_val    <= longint'(sq_in[0]);
                m_phase  <= 0;
                m_pulses <= 0;
                m_run    <= 1'b1;
            end else if (m_run && (pulse_limit < 0 || m_pulses < pulse_limit)) begin
                if (m_phase == 7) begin
                    m_phase  <= 0;
                    m_val    <= (m_val * m_val) % mod_n;
                    sq_out   <= mkvec((m_val * m_val) % mod_n);
                    sq_valid <= 1'b1;
                    m_pulses <= m_pulses + 1;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sq_start) starts <= starts + 1;
        if (sq_valid) valids <= valids + 1;
    end

    task automatic send_cmd(input longint t, input longint x);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_iters = IW'(t);
        cmd_x     = mkvec(x);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int bound);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (res_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL res_timeout: res_valid=%b required 1", res_valid);
        end
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if ({res_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL handshake: valid,busy=%b required 00", {res_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tbl_ready = 1'b1; cmd_valid = 1'b0; cmd_iters = '0;
        cmd_x = '0; abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_ready, res_valid, res_err, busy, sq_start} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {cmd_ready, res_valid, res_err, busy, sq_start});
        end
        vectors++;
        if (res_y !== '0 || res_done_cnt !== '0 || sq_in !== '0) begin
            miscompares++;
            $display("FAIL reset_data: y=%h cnt=%0d sq_in=%h required 0", res_y, res_done_cnt, sq_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int s0;
        mod_n = 1000003;
        s0 = starts;
        send_cmd(1, 3);
        vectors++;
        if (sq_start !== 1'b1 || sq_in !== mkvec(3)) begin
            miscompares++;
            $display("FAIL launch: sq_start=%b sq_in=%h required 1 / %h", sq_start, sq_in, mkvec(3));
        end
        wait_res(100);
        vectors++;
        if (res_y !== mkvec(9) || res_done_cnt !== 64'd1 || res_err !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_result: y=%h cnt=%0d err=%b required %h/1/0",
                     res_y, res_done_cnt, res_err, mkvec(9));
        end
        vectors++;
        if (starts - s0 !== 1) begin
            miscompares++;
            $display("FAIL t1_starts: %0d start pulses required 1", starts - s0);
        end
        handshake();
    endtask

    task automatic test_zero_iters();
        int s0;
        s0 = starts;
        send_cmd(0, 5);
        vectors++;
        if (res_valid !== 1'b1 || res_y !== mkvec(5) || res_done_cnt !== 64'd0 || res_err !== 1'b0) begin
            miscompares++;
            $display("FAIL t0_result: valid=%b y=%h cnt=%0d err=%b required 1/%h/0/0",
                     res_valid, res_y, res_done_cnt, res_err, mkvec(5));
        end
        vectors++;
        if (starts - s0 !== 0) begin
            miscompares++;
            $display("FAIL t0_starts: %0d start pulses required 0", starts - s0);
        end
        handshake();
    endtask

    task automatic test_hold();
        vec_t exp;
        int   v0;
        int   bad;
        mod_n = 131071;
        exp = mkvec(ref_pow(3, 100, 131071));
        send_cmd(100, 3);
        wait_res(1200);
        v0 = valids;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_y !== exp || res_done_cnt !== 64'd100) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable: %0d unstable cycles required 0, y=%h exp=%h", bad, res_y, exp);
        end
        vectors++;
        if (valids - v0 < 2) begin
            miscompares++;
            $display("FAIL hold_squarer: %0d sq_valid during hold required >=2", valids - v0);
        end
        handshake();
    endtask

    task automatic test_abort();
        int seen;
        int n;
        int bad;
        mod_n = 1000003;
        send_cmd(50, 3);
        seen = 0;
        n = 0;
        while (seen < 10 && n < 400) begin
            @(negedge clk);
            if (sq_valid === 1'b1) seen++;
            n++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({busy, res_valid} !== 2'b00 || seen != 10) begin
            miscompares++;
            $display("FAIL abort_idle: busy,valid=%b pulses=%0d required 00 / 10", {busy, res_valid}, seen);
        end
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL abort_quiet: %0d active cycles required 0", bad);
        end
        send_cmd(2, 3);
        wait_res(100);
        vectors++;
        if (res_y !== mkvec(81) || res_done_cnt !== 64'd2 || res_err !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort: y=%h cnt=%0d err=%b required %h/2/0",
                     res_y, res_done_cnt, res_err, mkvec(81));
        end
        handshake();
    endtask

    task automatic test_watchdog();
        mod_n = 1000003;
        pulse_limit = 3;
        send_cmd(10, 3);
        wait_res(300);
        vectors++;
        if (res_err !== 1'b1 || res_done_cnt !== 64'd3 || res_y !== mkvec(6561)) begin
            miscompares++;
            $display("FAIL wdog: err=%b cnt=%0d y=%h required 1/3/%h",
                     res_err, res_done_cnt, res_y, mkvec(6561));
        end
        handshake();
        pulse_limit = -1;
    endtask

    task automatic test_tbl_gate();
        int bad;
        tbl_ready = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_iters = 64'd1;
        cmd_x = mkvec(7);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL tbl_gate: %0d cycles ready/busy required 0", bad);
        end
        cmd_valid = 1'b0;
        tbl_ready = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        mod_n = 1000003;
        send_cmd(50, 3);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, res_valid, res_err, busy, sq_start} !== 5'b0 ||
            res_y !== '0 || res_done_cnt !== '0 || sq_in !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: ctrl=%b y=%h cnt=%0d sq_in=%h required all 0",
                     {cmd_ready, res_valid, res_err, busy, sq_start}, res_y, res_done_cnt, sq_in);
        end
        rst_n = 1'b1;
        send_cmd(1, 3);
        wait_res(100);
        vectors++;
        if (res_y !== mkvec(9) || res_done_cnt !== 64'd1) begin
            miscompares++;
            $display("FAIL post_reset: y=%h cnt=%0d required %h/1", res_y, res_done_cnt, mkvec(9));
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_iters();
        test_hold();
        test_abort();
        test_watchdog();
        test_tbl_gate();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not complete");
        $fatal(1);
    end

endmodule
